dm_access_ctrl: RTL

// - Memory-stage access controller, directly upstream of the load byte-extend stage.
// - Turns a pipeline load/store into one req/ack transaction on the data-memory bus:

---
 rtl/dm_access_ctrl_if.sv | 21 ++
 rtl/dm_access_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus between the M-stage access controller (master) and memory (slave).
// One req/ack transaction per access; read data is valid in the ack cycle.
interface dm_access_ctrl_if;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        m_data_we;
  logic        m_data_ack;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_req, m_data_addr, m_data_wdata, m_data_byteen, m_data_we,
    input  m_data_ack, m_data_rdata
  );

  modport slave (
    input  m_data_req, m_data_addr, m_data_wdata, m_data_byteen, m_data_we,
    output m_data_ack, m_data_rdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// M-stage load/store to data-memory bus controller with stall, timeout abort and
// optional misalignment trap (define ALIGN_CHECK_EN to enable).
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_load,
  input  logic             M_store,
  input  logic [1:0]       M_size,
  input  logic [31:0]      M_addr,
  input  logic [31:0]      M_wdata,
  dm_access_ctrl_if.master bus,
  output logic             M_stall,
  output logic [31:0]      M_rdata,
  output logic [1:0]       M_addr_lo,
  output logic             M_rvalid,
  output logic             M_bus_err,
  output logic             M_adel,
  output logic             M_ades
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  addr_lo_q;
  logic        access;
  logic [3:0]  byteen_c;
  logic [31:0] wdata_c;

  assign access  = M_load | M_store;
  // Gated by reset so the pipeline is released while the controller is held in reset.
  assign M_stall = reset & access & (state_q != StDone);

  always_comb begin
    byteen_c = 4'b1111;
    wdata_c  = M_wdata;
    case (M_size)
      2'b00: begin
        byteen_c = 4'b0001 << M_addr[1:0];
        wdata_c  = {4{M_wdata[7:0]}};
      end
      2'b01: begin
        byteen_c = M_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{M_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  logic misalign;
  logic adel_q;
  logic ades_q;

  assign misalign = (M_size == 2'b01) ? M_addr[0] : (M_size[1] & (M_addr[1:0] != 2'b00));
  assign M_adel   = adel_q;
  assign M_ades   = ades_q;
`else
  assign M_adel = 1'b0;
  assign M_ades = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      addr_lo_q         <= '0;
      bus.m_data_req    <= 1'b0;
      bus.m_data_addr   <= '0;
      bus.m_data_wdata  <= '0;
      bus.m_data_byteen <= '0;
      bus.m_data_we     <= 1'b0;
      M_rdata           <= '0;
      M_addr_lo         <= '0;
      M_rvalid          <= 1'b0;
      M_bus_err         <= 1'b0;
`ifdef ALIGN_CHECK_EN
      adel_q            <= 1'b0;
      ades_q            <= 1'b0;
`endif
    end else begin
      M_rvalid  <= 1'b0;
      M_bus_err <= 1'b0;
`ifdef ALIGN_CHECK_EN
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (access) begin
`ifdef ALIGN_CHECK_EN
            if (misalign) begin
              state_q   <= StDone;
              adel_q    <= M_load;
              ades_q    <= ~M_load;
              M_rdata   <= '0;
              M_addr_lo <= M_addr[1:0];
            end else
`endif
            begin
              state_q           <= StReq;
              cnt_q             <= '0;
              addr_lo_q         <= M_addr[1:0];
              bus.m_data_req    <= 1'b1;
              bus.m_data_addr   <= {M_addr[31:2], 2'b00};
              bus.m_data_wdata  <= wdata_c;
              // A load wins over a simultaneous store: no write lanes.
              bus.m_data_byteen <= M_load ? 4'b0000 : byteen_c;
              bus.m_data_we     <= ~M_load;
            end
          end
        end
        StReq: begin
          if (bus.m_data_ack) begin
            state_q        <= StDone;
            bus.m_data_req <= 1'b0;
            if (!bus.m_data_we) begin
              M_rdata   <= bus.m_data_rdata;
              M_addr_lo <= addr_lo_q;
              M_rvalid  <= 1'b1;
            end
          end else if (cnt_q == LastCnt) begin
            state_q        <= StDone;
            bus.m_data_req <= 1'b0;
            M_rdata        <= '0;
            M_addr_lo      <= addr_lo_q;
            M_bus_err      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
